// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared types for the RV32I decode stage.
//   t_rv_opcode : legal RV32I major opcodes
//   t_rv_instr  : raw instruction split into its fixed bit fields
//   t_uop       : micro-operation selector
//   t_uinstr    : registered decode result presented in DE1
//   alu_op()    : maps funct3 plus the alternate bit to an ALU uop
package rv_decode_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ALU_I  = 7'b0010011,
        OP_ALU_R  = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } t_rv_opcode;

    // The opcode field stays plain logic because illegal encodings must be representable.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } t_rv_instr;

    // U_NOP is zero so that an all-zero uop is the reset value.
    typedef enum logic [4:0] {
        U_NOP   = 5'd0,
        U_ADD   = 5'd1,
        U_SUB   = 5'd2,
        U_SLL   = 5'd3,
        U_SLT   = 5'd4,
        U_SLTU  = 5'd5,
        U_XOR   = 5'd6,
        U_SRL   = 5'd7,
        U_SRA   = 5'd8,
        U_OR    = 5'd9,
        U_AND   = 5'd10,
        U_LUI   = 5'd11,
        U_AUIPC = 5'd12,
        U_JAL   = 5'd13,
        U_JALR  = 5'd14,
        U_BR    = 5'd15,
        U_LD    = 5'd16,
        U_ST    = 5'd17,
        U_FENCE = 5'd18,
        U_SYS   = 5'd19
    } t_uop;

    typedef struct packed {
        t_uop        uop;
        logic        illegal;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } t_uinstr;

    // alt selects SUB (funct3=000) or SRA (funct3=101); ignored elsewhere.
    function automatic t_uop alu_op(input logic [2:0] f3, input logic alt);
        t_uop op;
        case (f3)
            3'b000:  op = alt ? U_SUB : U_ADD;
            3'b001:  op = U_SLL;
            3'b010:  op = U_SLT;
            3'b011:  op = U_SLTU;
            3'b100:  op = U_XOR;
            3'b101:  op = alt ? U_SRA : U_SRL;
            3'b110:  op = U_OR;
            default: op = U_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decode_if.sv
// rv_decode_if: DE0 -> DE1 decode bus.
//   instr_de0  : raw instruction entering decode
//   uinstr_de1 : registered micro-instruction leaving decode
//   master     : fetch side (drives instr_de0)
//   slave      : decode stage (drives uinstr_de1)
interface rv_decode_if;
    import rv_decode_pkg::*;

    t_rv_instr instr_de0;
    t_uinstr   uinstr_de1;

    modport master (output instr_de0, input uinstr_de1);
    modport slave  (input instr_de0, output uinstr_de1);
endinterface

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational immediate extraction for RV32I.
//   i_instr : raw instruction
//   o_imm   : 32-bit immediate, sign-extended from instr[31]; 0 for R/FENCE/unknown
module rv_imm_gen
    import rv_decode_pkg::*;
(
    input  t_rv_instr   i_instr,
    output logic [31:0] o_imm
);

    logic [31:0] w_ins;
    assign w_ins = i_instr;

    always_comb begin
        o_imm = '0;
        case (i_instr.opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM:
                o_imm = {{20{w_ins[31]}}, w_ins[31:20]};
            OP_ALU_I:
                // Shift-immediates carry only a 5-bit shamt; funct7 bits are not part of it.
                if (i_instr.funct3 == 3'b001 || i_instr.funct3 == 3'b101)
                    o_imm = {27'b0, w_ins[24:20]};
                else
                    o_imm = {{20{w_ins[31]}}, w_ins[31:20]};
            OP_STORE:
                o_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            OP_BRANCH:
                o_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                o_imm = {w_ins[31:12], 12'b0};
            OP_JAL:
                o_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode.sv
// rv_decode: RV32I decode stage, one-cycle latency DE0 -> DE1, no stall.
//   clk   : core clock
//   reset : synchronous active-high reset, clears the DE1 uop to all zero
//   bus   : rv_decode_if.slave (instr_de0 in, uinstr_de1 out)
module rv_decode
    import rv_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    rv_decode_if.slave  bus
);

    t_rv_instr   w_ins;
    logic [31:0] w_imm;
    t_uinstr     w_dec;
    t_uinstr     r_uinstr;
    t_uop        w_op;
    logic        w_rs1;
    logic        w_rs2;
    logic        w_wr;
    logic        w_ill;

    assign w_ins = bus.instr_de0;

    rv_imm_gen u_imm_gen (
        .i_instr (w_ins),
        .o_imm   (w_imm)
    );

    always_comb begin
        w_op  = U_NOP;
        w_rs1 = 1'b0;
        w_rs2 = 1'b0;
        w_wr  = 1'b0;
        w_ill = 1'b0;
        case (w_ins.opcode)
            OP_ALU_R: begin
                w_rs1 = 1'b1;
                w_rs2 = 1'b1;
                w_wr  = 1'b1;
                if (w_ins.funct7 == 7'b0000000)
                    w_op = alu_op(w_ins.funct3, 1'b0);
                else if (w_ins.funct7 == 7'b0100000 &&
                         (w_ins.funct3 == 3'b000 || w_ins.funct3 == 3'b101))
                    w_op = alu_op(w_ins.funct3, 1'b1);
                else
                    w_ill = 1'b1;
            end
            OP_ALU_I: begin
                w_rs1 = 1'b1;
                w_wr  = 1'b1;
                // No SUBI exists, so the alternate bit only matters for the right shift.
                w_op  = alu_op(w_ins.funct3,
                               (w_ins.funct3 == 3'b101) && (w_ins.funct7 == 7'b0100000));
            end
            OP_LUI: begin
                w_wr = 1'b1;
                w_op = U_LUI;
            end
            OP_AUIPC: begin
                w_wr = 1'b1;
                w_op = U_AUIPC;
            end
            OP_JAL: begin
                w_wr = 1'b1;
                w_op = U_JAL;
            end
            OP_JALR: begin
                w_rs1 = 1'b1;
                w_wr  = 1'b1;
                w_op  = U_JALR;
                w_ill = (w_ins.funct3 != 3'b000);
            end
            OP_BRANCH: begin
                w_rs1 = 1'b1;
                w_rs2 = 1'b1;
                w_op  = U_BR;
                w_ill = (w_ins.funct3 == 3'b010) || (w_ins.funct3 == 3'b011);
            end
            OP_LOAD: begin
                w_rs1 = 1'b1;
                w_wr  = 1'b1;
                w_op  = U_LD;
                w_ill = (w_ins.funct3 == 3'b011) || (w_ins.funct3 == 3'b110) ||
                        (w_ins.funct3 == 3'b111);
            end
            OP_STORE: begin
                w_rs1 = 1'b1;
                w_rs2 = 1'b1;
                w_op  = U_ST;
                w_ill = (w_ins.funct3 > 3'b010);
            end
            OP_FENCE: begin
                w_op = U_FENCE;
            end
            OP_SYSTEM: begin
                w_rs1 = 1'b1;
                w_wr  = 1'b1;
                w_op  = U_SYS;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase

        w_dec           = '0;
        w_dec.opcode    = w_ins.opcode;
        w_dec.funct3    = w_ins.funct3;
        w_dec.funct7    = w_ins.funct7;
        w_dec.rd        = w_ins.rd;
        w_dec.rs1       = w_ins.rs1;
        w_dec.rs2       = w_ins.rs2;
        w_dec.imm       = w_imm;
        w_dec.illegal   = w_ill;
        // An illegal instruction must not touch the register file or scoreboard.
        w_dec.uop       = w_ill ? U_NOP : w_op;
        w_dec.uses_rs1  = w_rs1 & ~w_ill;
        w_dec.uses_rs2  = w_rs2 & ~w_ill;
        w_dec.writes_rd = w_wr & ~w_ill & (w_ins.rd != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_uinstr <= '0;
        else
            r_uinstr <= w_dec;
    end

    assign bus.uinstr_de1 = r_uinstr;

endmodule

// File: tb/tb_rv_decode.sv
// tb_rv_decode: directed-vector bench for rv_decode.
module tb_rv_decode;
    import rv_decode_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    rv_decode_if bus ();

    rv_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every decoded field of the current DE1 uop against expected values.
    task automatic chk_uop(input string tag, input t_uop uop, input logic ill,
                           input logic u1, input logic u2, input logic wr,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        t_uinstr u;
        u = bus.uinstr_de1;
        chk({tag, ".uop"},  80'(u.uop),       80'(uop));
        chk({tag, ".ill"},  80'(u.illegal),   80'(ill));
        chk({tag, ".urs1"}, 80'(u.uses_rs1),  80'(u1));
        chk({tag, ".urs2"}, 80'(u.uses_rs2),  80'(u2));
        chk({tag, ".wrd"},  80'(u.writes_rd), 80'(wr));
        chk({tag, ".rd"},   80'(u.rd),        80'(rd));
        chk({tag, ".rs1"},  80'(u.rs1),       80'(rs1));
        chk({tag, ".rs2"},  80'(u.rs2),       80'(rs2));
        chk({tag, ".imm"},  80'(u.imm),       80'(imm));
    endtask

    // Drive at negedge; the uop is captured on the following posedge and sampled at the next negedge.
    task automatic step(input logic [31:0] instr);
        bus.instr_de0 = instr;
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.instr_de0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_all", 80'(bus.uinstr_de1), 80'd0);
        reset = 1'b0;

        //                          uop     ill u1 u2 wr rd  rs1 rs2 imm
        step(32'h00000033); chk_uop("add0",  U_ADD,  0, 1, 1, 0, 0,  0,  0,  32'h0);
        chk("add0.op", 80'(bus.uinstr_de1.opcode), 80'(7'h33));
        step(32'h40B50533); chk_uop("sub",   U_SUB,  0, 1, 1, 1, 10, 10, 11, 32'h0);
        chk("sub.f7", 80'(bus.uinstr_de1.funct7), 80'(7'h20));
        step(32'hFFF00093); chk_uop("addi",  U_ADD,  0, 1, 0, 1, 1,  0,  31, 32'hFFFFFFFF);
        step(32'h00512423); chk_uop("sw",    U_ST,   0, 1, 1, 0, 8,  2,  5,  32'h00000008);
        chk("sw.f3", 80'(bus.uinstr_de1.funct3), 80'(3'b010));
        step(32'h123450B7); chk_uop("lui",   U_LUI,  0, 0, 0, 1, 1,  8,  3,  32'h12345000);
        step(32'h00000000); chk_uop("zero",  U_NOP,  1, 0, 0, 0, 0,  0,  0,  32'h0);
        step(32'h40525193); chk_uop("srai",  U_SRA,  0, 1, 0, 1, 3,  4,  5,  32'h00000005);
        step(32'h00525193); chk_uop("srli",  U_SRL,  0, 1, 0, 1, 3,  4,  5,  32'h00000005);
        step(32'hFE208EE3); chk_uop("beq",   U_BR,   0, 1, 1, 0, 29, 1,  2,  32'hFFFFFFFC);
        step(32'h001000EF); chk_uop("jal",   U_JAL,  0, 0, 0, 1, 1,  0,  1,  32'h00000800);
        step(32'hFF832283); chk_uop("lw",    U_LD,   0, 1, 0, 1, 5,  6,  24, 32'hFFFFFFF8);

        // Illegal-encoding corners: uop and flags are suppressed, fields still pass.
        step(32'h00002063);
        chk("br_f3_010.ill", 80'(bus.uinstr_de1.illegal), 80'd1);
        chk("br_f3_010.uop", 80'(bus.uinstr_de1.uop),     80'(U_NOP));
        chk("br_f3_010.u1",  80'(bus.uinstr_de1.uses_rs1), 80'd0);
        step(32'h40001033);
        chk("sll_alt.ill",   80'(bus.uinstr_de1.illegal), 80'd1);
        chk("sll_alt.f7",    80'(bus.uinstr_de1.funct7),  80'(7'h20));
        step(32'h020000B3);
        chk("mul.ill",       80'(bus.uinstr_de1.illegal), 80'd1);
        chk("mul.wrd",       80'(bus.uinstr_de1.writes_rd), 80'd0);
        step(32'h000070A3);
        chk("st_f3_111.ill", 80'(bus.uinstr_de1.illegal), 80'd1);
        step(32'h000010E7);
        chk("jalr_f3.ill",   80'(bus.uinstr_de1.illegal), 80'd1);
        step(32'h000030A3);
        chk("st_f3_011.ill", 80'(bus.uinstr_de1.illegal), 80'd1);

        // Mid-stream reset: one cycle of all-zero output, then normal decode.
        step(32'h40B50533); chk_uop("pre_rst", U_SUB, 0, 1, 1, 1, 10, 10, 11, 32'h0);
        reset = 1'b1;
        step(32'hFFF00093);
        chk("mid_rst_all", 80'(bus.uinstr_de1), 80'd0);
        reset = 1'b0;
        step(32'h00512423); chk_uop("post_rst", U_ST, 0, 1, 1, 0, 8, 2, 5, 32'h00000008);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
